// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - fetch PC owner, in-order imem requester and DEPTH-entry instruction queue
// Optional feature macro: FETCH_BYPASS_EN (combinational forwarding of a fill into an empty head)
module inst_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    redirect,
  input  logic [31:0]             redirect_pc,
  output logic                    imem_req,
  output logic [31:0]             imem_addr,
  input  logic                    imem_gnt,
  input  logic                    imem_rvalid,
  input  logic [31:0]             imem_rdata,
  input  logic                    deq,
  output logic                    instr_valid,
  output logic [31:0]             instr,
  output logic [31:0]             pc_out,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic {S_FETCH, S_DISCARD} state_t;

  state_t          state_q, state_d;
  logic            run_q, run_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [PW-1:0]   fill_q, fill_d;
  logic [PW-1:0]   discard_cnt_q, discard_cnt_d;
  logic [DEPTH-1:0] rdy_q, rdy_d;

  logic [31:0]     pc_mem_q   [DEPTH];
  logic [31:0]     data_mem_q [DEPTH];

  logic [AW-1:0]   head_idx, tail_idx, fill_idx;
  logic [PW-1:0]   inflight;
  logic            full, head_rdy, fill_en, fill_wr, bypass_hit;
  logic            pop, grant, alloc, old_resp;

  // Queue status, head outputs and request generation
  always_comb begin
    head_idx = head_q[AW-1:0];
    tail_idx = tail_q[AW-1:0];
    fill_idx = fill_q[AW-1:0];
    full     = (head_q[AW] != tail_q[AW]) && (head_idx == tail_idx);
    count    = tail_q - head_q;
    inflight = tail_q - fill_q;
    head_rdy = rdy_q[head_idx];
    // A response belongs to an old request only if something is still unfilled
    old_resp = imem_rvalid && (inflight != '0);
    fill_en  = (state_q == S_FETCH) && old_resp && !redirect;
`ifdef FETCH_BYPASS_EN
    // No ready entry means the oldest unfilled slot is the head itself
    bypass_hit = fill_en && !head_rdy;
`else
    bypass_hit = 1'b0;
`endif
    instr_valid = head_rdy || bypass_hit;
    if (head_rdy) begin
      instr = data_mem_q[head_idx];
    end else if (bypass_hit) begin
      instr = imem_rdata;
    end else begin
      instr = 32'h0;
    end
    pc_out    = instr_valid ? pc_mem_q[head_idx] : 32'h0;
    pop       = deq && instr_valid && !redirect;
    imem_req  = run_q && (state_q == S_FETCH) && (!full || pop);
    imem_addr = fetch_pc_q;
    grant     = imem_req && imem_gnt;
    alloc     = grant && !redirect;
    // A bypassed word that is consumed immediately never needs a slot write
    fill_wr   = fill_en && !(bypass_hit && pop);
  end

  // Next-state logic: pointers, ready bits, fetch PC and discard bookkeeping
  always_comb begin
    state_d       = state_q;
    run_d         = 1'b1;
    fetch_pc_d    = fetch_pc_q;
    head_d        = head_q;
    tail_d        = tail_q;
    fill_d        = fill_q;
    discard_cnt_d = discard_cnt_q;
    rdy_d         = rdy_q;
    case (state_q)
      S_FETCH: begin
        if (redirect) begin
          // Everything in flight, including a same-cycle grant, must be drained;
          // a same-cycle response completes an old request and is dropped here
          rdy_d         = '0;
          head_d        = '0;
          tail_d        = '0;
          fill_d        = '0;
          fetch_pc_d    = redirect_pc;
          discard_cnt_d = inflight + PW'(grant) - PW'(old_resp);
          state_d       = (discard_cnt_d != '0) ? S_DISCARD : S_FETCH;
        end else begin
          if (pop) begin
            rdy_d[head_idx] = 1'b0;
            head_d          = head_q + PW'(1);
          end
          if (fill_en) begin
            if (fill_wr) begin
              rdy_d[fill_idx] = 1'b1;
            end
            fill_d = fill_q + PW'(1);
          end
          if (grant) begin
            rdy_d[tail_idx] = 1'b0;
            tail_d          = tail_q + PW'(1);
            fetch_pc_d      = fetch_pc_q + 32'd4;
          end
        end
      end
      S_DISCARD: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc;
        end
        if (imem_rvalid && (discard_cnt_q != '0)) begin
          discard_cnt_d = discard_cnt_q - PW'(1);
          if (discard_cnt_q == PW'(1)) begin
            state_d = S_FETCH;
          end
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Control state registers with asynchronous clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_FETCH;
      run_q         <= 1'b0;
      fetch_pc_q    <= RESET_PC;
      head_q        <= '0;
      tail_q        <= '0;
      fill_q        <= '0;
      discard_cnt_q <= '0;
      rdy_q         <= '0;
    end else begin
      state_q       <= state_d;
      run_q         <= run_d;
      fetch_pc_q    <= fetch_pc_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      fill_q        <= fill_d;
      discard_cnt_q <= discard_cnt_d;
      rdy_q         <= rdy_d;
    end
  end

  // Slot payload storage; validity is tracked by rdy_q so no reset is needed
  always_ff @(posedge clk) begin
    if (alloc) begin
      pc_mem_q[tail_idx] <= imem_addr;
    end
    if (fill_wr) begin
      data_mem_q[fill_idx] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb/tb_inst_fetch_queue.sv - scoreboard bench for inst_fetch_queue with a latency-programmable memory
module tb_inst_fetch_queue;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        deq = 1'b0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc_out;
  logic [2:0]  count;

  inst_fetch_queue #(.DEPTH(4), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .deq(deq),
    .instr_valid(instr_valid), .instr(instr), .pc_out(pc_out), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; logic stale; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;

  req_t        pend[$];
  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lat = 1;
  int          mcount = 0;
  logic [31:0] exp_fetch_pc = RESET_PC;
  logic        special_data = 1'b0;
  int          pops = 0;
  int          grants = 0;
  int          max_count = 0;
  logic [31:0] pop_pcs[8];
  logic        o_req, o_valid;
  logic [31:0] o_addr, o_instr, o_pc;
  logic [2:0]  o_count;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (special_data && a == 32'h0) return 32'h2402_0005;
    return a ^ 32'h0000_FFFF;
  endfunction

  task automatic clear_stats();
    pops = 0; grants = 0; max_count = 0;
  endtask

  task automatic model_reset();
    pend.delete();
    exp_q.delete();
    mcount = 0;
    exp_fetch_pc = RESET_PC;
    cyc = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; redirect = 1'b0; deq = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    model_reset();
    clear_stats();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("req_low_after_rst", {31'h0, imem_req}, 32'h0);
  endtask

  // One cycle: drive at the falling edge, sample 1 time unit later, update the model
  task automatic cycle_step(input logic dq, input logic rd, input logic [31:0] rpc);
    req_t r;
    exp_t e;
    logic pop_now, grant_now;
    @(negedge clk);
    deq = dq; redirect = rd; redirect_pc = rpc;
    imem_rvalid = 1'b0; imem_rdata = 32'h0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      r = pend.pop_front();
      imem_rvalid = 1'b1;
      imem_rdata  = mem_data(r.addr);
      if (!r.stale && !rd) begin
        e.pc = r.addr; e.data = imem_rdata;
        exp_q.push_back(e);
      end
    end
    #1;
    o_req = imem_req; o_addr = imem_addr; o_valid = instr_valid;
    o_instr = instr; o_pc = pc_out; o_count = count;
    if (int'(o_count) > max_count) max_count = int'(o_count);
    check("count", {29'h0, o_count}, mcount);
    if (o_req) check("imem_addr", o_addr, exp_fetch_pc);
    pop_now   = dq && o_valid && !rd;
    grant_now = o_req && imem_gnt;
    if (pop_now) begin
      if (exp_q.size() == 0) begin
        check("pop_unexpected", 32'h1, 32'h0);
      end else begin
        e = exp_q.pop_front();
        check("pc_out", o_pc, e.pc);
        check("instr", o_instr, e.data);
      end
      if (pops < 8) pop_pcs[pops] = o_pc;
      pops++;
    end
    if (rd) begin
      foreach (pend[i]) pend[i].stale = 1'b1;
      exp_q.delete();
    end
    if (grant_now) begin
      r.addr = exp_fetch_pc; r.due = cyc + lat; r.stale = rd;
      pend.push_back(r);
      grants++;
    end
    if (rd) mcount = 0;
    else    mcount = mcount + int'(grant_now) - int'(pop_now);
    if (rd)             exp_fetch_pc = rpc;
    else if (grant_now) exp_fetch_pc = exp_fetch_pc + 32'd4;
    cyc++;
  endtask

  task automatic run(input int n, input logic dq);
    for (int i = 0; i < n; i++) cycle_step(dq, 1'b0, 32'h0);
  endtask

  initial begin
    // Reset values before any clock edge
    #1 rst = 1'b0;
    #1;
    check("rst_req", {31'h0, imem_req}, 32'h0);
    check("rst_addr", imem_addr, RESET_PC);
    check("rst_valid", {31'h0, instr_valid}, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_pc", pc_out, 32'h0);
    check("rst_count", {29'h0, count}, 32'h0);

    // Single-cycle memory, continuous dequeue
    lat = 1;
    do_reset();
    run(20, 1'b1);
`ifdef FETCH_BYPASS_EN
    check("t1_pops", pops, 19);
`else
    check("t1_pops", pops, 18);
`endif
    check("t1_first_pc", pop_pcs[0], 32'h0);
    check("t1_third_pc", pop_pcs[2], 32'h8);
    check("t1_max_count", {31'h0, max_count <= 2}, 32'h1);

    // Decode stalled: queue fills to DEPTH, then drains in order
    do_reset();
    run(10, 1'b0);
    check("t2_grants", grants, 4);
    check("t2_req_full", {31'h0, o_req}, 32'h0);
    check("t2_count_full", {29'h0, o_count}, 32'h4);
    clear_stats();
    run(8, 1'b1);
    check("t2_pop0", pop_pcs[0], 32'h0);
    check("t2_pop1", pop_pcs[1], 32'h4);
    check("t2_pop2", pop_pcs[2], 32'h8);
    check("t2_pop3", pop_pcs[3], 32'hC);

    // Latency 3, three outstanding, redirect: drain three stale responses
    lat = 3;
    do_reset();
    run(2, 1'b1);
    cycle_step(1'b1, 1'b1, 32'h100);
    for (int i = 0; i < 3; i++) begin
      cycle_step(1'b1, 1'b0, 32'h0);
      check("t3_discard_req", {31'h0, o_req}, 32'h0);
      check("t3_discard_valid", {31'h0, o_valid}, 32'h0);
    end
    clear_stats();
    cycle_step(1'b1, 1'b0, 32'h0);
    check("t3_restart_req", {31'h0, o_req}, 32'h1);
    check("t3_restart_addr", o_addr, 32'h100);
    run(10, 1'b1);
    check("t3_pops_seen", {31'h0, pops > 0}, 32'h1);
    check("t3_first_pc", pop_pcs[0], 32'h100);

    // Redirect together with grant, response and dequeue
    lat = 1;
    do_reset();
    run(6, 1'b1);
    cycle_step(1'b1, 1'b1, 32'h200);
    cycle_step(1'b1, 1'b0, 32'h0);
    check("t4_discard_req", {31'h0, o_req}, 32'h0);
    check("t4_valid_cleared", {31'h0, o_valid}, 32'h0);
    clear_stats();
    cycle_step(1'b1, 1'b0, 32'h0);
    check("t4_restart_req", {31'h0, o_req}, 32'h1);
    check("t4_restart_addr", o_addr, 32'h200);
    run(6, 1'b1);
    check("t4_first_pc", pop_pcs[0], 32'h200);

    // Asynchronous reset with a full queue
    do_reset();
    run(8, 1'b0);
    check("t5_full_valid", {31'h0, o_valid}, 32'h1);
    @(negedge clk);
    imem_rvalid = 1'b0; deq = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("t5_async_valid", {31'h0, instr_valid}, 32'h0);
    check("t5_async_count", {29'h0, count}, 32'h0);
    check("t5_async_req", {31'h0, imem_req}, 32'h0);
    check("t5_async_addr", imem_addr, RESET_PC);
    check("t5_async_pc", pc_out, 32'h0);
    check("t5_async_instr", instr, 32'h0);
    model_reset();
    clear_stats();
    @(negedge clk);
    rst = 1'b1;
    run(8, 1'b1);
    check("t5_restart_pc", pop_pcs[0], RESET_PC);

    // Fill into an empty queue: bypass latency versus registered latency
    special_data = 1'b1;
    do_reset();
    cycle_step(1'b0, 1'b0, 32'h0);
    cycle_step(1'b1, 1'b0, 32'h0);
`ifdef FETCH_BYPASS_EN
    check("t6_bypass_valid", {31'h0, o_valid}, 32'h1);
    check("t6_bypass_instr", o_instr, 32'h2402_0005);
`else
    check("t6_reg_valid_early", {31'h0, o_valid}, 32'h0);
    cycle_step(1'b1, 1'b0, 32'h0);
    check("t6_reg_valid", {31'h0, o_valid}, 32'h1);
    check("t6_reg_instr", o_instr, 32'h2402_0005);
`endif
    special_data = 1'b0;
    run(4, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Fetch-stage front end for the 5-stage MIPS pipeline: owns the fetch PC, issues in-order requests to a variable-latency instruction memory, and buffers returned words with their PCs in a DEPTH-entry FIFO. Decode pops one instruction per cycle when not stalled. Branch, jump and mispredict recovery from the datapath arrive as a single redirect that flushes the queue and discards in-flight responses.

## Interface
- DEPTH, 4, queue entries; power of two, 2..16
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- redirect  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  32  new fetch address, word aligned
- imem_req  out  1  request valid
- imem_addr  out  32  request address
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  response valid, in request order
- imem_rdata  in  32  response word
- deq  in  1  decode consumes head (driven by ~stallD)
- instr_valid  out  1  head entry holds returned data
- instr  out  32  head instruction
- pc_out  out  32  PC of head instruction
- count  out  $clog2(DEPTH)+1  allocated entries (filled + in flight)

## Operation
- Entry allocated at grant (imem_req & imem_gnt): slot stores imem_addr, ready=0. Response fills oldest unfilled slot, ready=1.
- imem_req=1 when state FETCH and count < DEPTH (including slot freed by deq same cycle). imem_addr = fetch_pc; fetch_pc += 4 on grant. Address/request held stable until granted unless redirect.
- Head pop on deq & instr_valid; deq while !instr_valid ignored.
- States: FETCH, DISCARD.
  - FETCH: normal operation. On redirect: all slots cleared, fetch_pc <= redirect_pc; discard_cnt <= unfilled in-flight count (including a grant in the same cycle, excluding an rvalid in the same cycle if it completes an old request — that response is itself dropped). Go DISCARD if discard_cnt>0, else stay FETCH.
  - DISCARD: imem_req=0; each rvalid decrements discard_cnt, data dropped; at 0 go FETCH. Redirect in DISCARD updates fetch_pc only.
- Simultaneous: redirect beats deq, grant and fill; deq on full + grant same cycle legal.
- Wrap-around: head/tail pointers one bit wider than index; full = msb differ, rest equal.
- rvalid with no outstanding request: ignored (assertion in bench).

## Timing
- Reset (rst=0, async): state FETCH, fetch_pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, pc_out=0, count=0, discard_cnt=0. imem_req rises first clk edge after rst deasserts.
- Grant at edge t -> rvalid earliest in cycle t+1 -> instr_valid cycle t+2 (registered fill).
- Redirect at edge t -> instr_valid=0 from t+1; new imem_addr presented in t+1 if no in-flight discards.
- Throughput: 1 instruction/cycle with single-cycle memory and DEPTH≥2.
- Reset mid-operation: all state cleared immediately; responses arriving after reset are not discarded (memory must be reset together).

## Configuration
- FETCH_BYPASS_EN defined: when queue holds no ready entry and rvalid fills head, instr_valid/instr/pc_out driven combinationally from imem_rdata same cycle; deq that cycle pops without a write. Latency grant->instr_valid = 1 cycle.
- Undefined: outputs purely registered from the queue; latency 2 cycles as above.

## Test plan
- Reset, single-cycle memory (gnt=1, rvalid next cycle, rdata=addr^32'hFFFF), deq=1: pc_out sequence 0,4,8,... one per cycle, instr matches rdata, count≤2.
- deq=0 for 10 cycles: exactly DEPTH=4 grants, imem_req=0 with count=4; deq=1 then pops PCs 0,4,8,12 in order.
- Memory latency 3 cycles, 3 outstanding, redirect to 32'h100: three old responses dropped, state DISCARD 3 cycles, first instr_valid has pc_out=32'h100.
- Redirect, grant and rvalid in same cycle with deq=1: no pop occurs, granted request discarded, next fetch at redirect_pc.
- Assert rst=0 mid-stream with queue full: outputs zero immediately without clock; restart fetches RESET_PC.
- With FETCH_BYPASS_EN: empty queue, rvalid with rdata=32'h2402_0005 -> instr_valid=1 same cycle, instr=32'h2402_0005.
